// File: rtl/l2_cache_ctrl_assoc_if.sv
// Bus bundle between the L2 associative controller and its datapath/pmem.
// master = controller side, slave = datapath/memory side.
interface l2_cache_ctrl_assoc_if #(
    parameter int NUM_WAYS    = 4,
    parameter int BURST_BEATS = 4
);
    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int BEAT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;

    logic                mem_read;
    logic                mem_write;
    logic [NUM_WAYS-1:0] hit_vec;
    logic [NUM_WAYS-1:0] valid_vec;
    logic [NUM_WAYS-1:0] dirty_vec;
    logic [WAY_W-1:0]    lru_way;
    logic                pmem_resp;
    logic [WAY_W-1:0]    way_sel;
    logic                pmem_addr_sel;
    logic                pmem_read;
    logic                pmem_write;
    logic [BEAT_W-1:0]   beat_idx;
    logic                load_data;
    logic                load_tag;
    logic                set_dirty;
    logic                lru_update;
    logic                mem_resp;

    modport master (
        input  mem_read, mem_write, hit_vec, valid_vec,
        input  dirty_vec, lru_way, pmem_resp,
        output way_sel, pmem_addr_sel, pmem_read, pmem_write,
        output beat_idx, load_data, load_tag, set_dirty,
        output lru_update, mem_resp
    );

    modport slave (
        output mem_read, mem_write, hit_vec, valid_vec,
        output dirty_vec, lru_way, pmem_resp,
        input  way_sel, pmem_addr_sel, pmem_read, pmem_write,
        input  beat_idx, load_data, load_tag, set_dirty,
        input  lru_update, mem_resp
    );
endinterface

// File: rtl/l2_cache_ctrl_assoc.sv
// N-way set-associative L2 control FSM.
// Zero-wait hits, burst write-back/fill, completes bursts on dropped requests.
module l2_cache_ctrl_assoc #(
    parameter int NUM_WAYS    = 4,
    parameter int BURST_BEATS = 4
) (
    input  logic clk,
    input  logic reset,
    l2_cache_ctrl_assoc_if.master bus
);
    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int BEAT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;

    localparam logic [1:0] CHECK  = 2'd0;
    localparam logic [1:0] EVICT  = 2'd1;
    localparam logic [1:0] FILL   = 2'd2;
    localparam logic [1:0] UPDATE = 2'd3;

    logic [1:0]        state;
    logic [BEAT_W-1:0] cnt;
    logic [WAY_W-1:0]  victim;
    logic              drop;

    logic [WAY_W-1:0]  hit_idx;
    logic [WAY_W-1:0]  inv_idx;
    logic [WAY_W-1:0]  vic_next;
    logic              inv_any;
    logic              vic_dirty;
    logic              req;
    logic              hit;
    logic              last;

    assign req  = bus.mem_read | bus.mem_write;
    assign hit  = |bus.hit_vec;
    assign last = (cnt == BEAT_W'(BURST_BEATS - 1));

    // lowest-index hit way and lowest-index invalid way
    always_comb begin
        hit_idx = '0;
        inv_idx = '0;
        inv_any = 1'b0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (bus.hit_vec[i]) begin
                hit_idx = WAY_W'(i);
            end
            if (!bus.valid_vec[i]) begin
                inv_idx = WAY_W'(i);
                inv_any = 1'b1;
            end
        end
    end

    assign vic_next  = inv_any ? inv_idx : bus.lru_way;
    assign vic_dirty = bus.valid_vec[vic_next] & bus.dirty_vec[vic_next];

    // state, beat counter, victim and dropped-request flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= CHECK;
            cnt    <= '0;
            victim <= '0;
            drop   <= 1'b0;
        end else begin
            unique case (state)
                CHECK: begin
                    if (req && !hit) begin
                        victim <= vic_next;
                        cnt    <= '0;
                        drop   <= 1'b0;
                        state  <= vic_dirty ? EVICT : FILL;
                    end
                end
                EVICT: begin
                    if (!req) begin
                        drop <= 1'b1;
                    end
                    if (bus.pmem_resp) begin
                        if (last) begin
                            cnt   <= '0;
                            state <= (drop || !req) ? CHECK : FILL;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (bus.pmem_resp) begin
                        if (last) begin
                            cnt   <= '0;
                            state <= UPDATE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                UPDATE: begin
                    state <= CHECK;
                end
                default: begin
                    state <= CHECK;
                end
            endcase
        end
    end

    // per-state strobes; everything held low while in reset
    always_comb begin
        bus.way_sel       = '0;
        bus.pmem_addr_sel = 1'b0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        bus.beat_idx      = '0;
        bus.load_data     = 1'b0;
        bus.load_tag      = 1'b0;
        bus.set_dirty     = 1'b0;
        bus.lru_update    = 1'b0;
        bus.mem_resp      = 1'b0;
        if (!reset) begin
            unique case (state)
                CHECK: begin
                    if (req && hit) begin
                        bus.way_sel    = hit_idx;
                        bus.lru_update = 1'b1;
                        bus.set_dirty  = bus.mem_write;
                        bus.mem_resp   = 1'b1;
                    end
                end
                EVICT: begin
                    bus.way_sel       = victim;
                    bus.pmem_addr_sel = 1'b1;
                    bus.pmem_write    = 1'b1;
                    bus.beat_idx      = cnt;
                end
                FILL: begin
                    bus.way_sel   = victim;
                    bus.pmem_read = 1'b1;
                    bus.beat_idx  = cnt;
                    bus.load_data = bus.pmem_resp;
                end
                UPDATE: begin
                    bus.way_sel  = victim;
                    bus.load_tag = 1'b1;
                end
                default: begin
                    bus.way_sel = '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_l2_cache_ctrl_assoc.sv
// Scoreboard bench for l2_cache_ctrl_assoc.
// Two instances: 4-way/4-beat and 2-way/1-beat.
module tb_l2_cache_ctrl_assoc;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    l2_cache_ctrl_assoc_if #(.NUM_WAYS(4), .BURST_BEATS(4)) a ();
    l2_cache_ctrl_assoc_if #(.NUM_WAYS(2), .BURST_BEATS(1)) b ();

    l2_cache_ctrl_assoc #(.NUM_WAYS(4), .BURST_BEATS(4)) dut_a (
        .clk  (clk),
        .reset(rst),
        .bus  (a)
    );

    l2_cache_ctrl_assoc #(.NUM_WAYS(2), .BURST_BEATS(1)) dut_b (
        .clk  (clk),
        .reset(rst),
        .bus  (b)
    );

    // observed bundle: {way[1:0],asel,rd,wr,beat[1:0],ld,lt,sd,lru,resp}
    logic [11:0] obs_a;
    logic [11:0] obs_b;

    assign obs_a = {a.way_sel, a.pmem_addr_sel, a.pmem_read,
                    a.pmem_write, a.beat_idx, a.load_data,
                    a.load_tag, a.set_dirty, a.lru_update,
                    a.mem_resp};
    assign obs_b = {1'b0, b.way_sel, b.pmem_addr_sel, b.pmem_read,
                    b.pmem_write, 1'b0, b.beat_idx, b.load_data,
                    b.load_tag, b.set_dirty, b.lru_update,
                    b.mem_resp};

    typedef struct {
        int          dut;
        logic [11:0] exp;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;

    localparam logic [11:0] E0 = 12'd0;

    function automatic logic [11:0] e_hit(logic [1:0] w, logic sd);
        return {w, 3'b000, 2'b00, 1'b0, 1'b0, sd, 1'b1, 1'b1};
    endfunction

    function automatic logic [11:0] e_evict(logic [1:0] w, logic [1:0] bt);
        return {w, 1'b1, 1'b0, 1'b1, bt, 5'b00000};
    endfunction

    function automatic logic [11:0] e_fill(logic [1:0] w, logic [1:0] bt,
                                           logic ld);
        return {w, 1'b0, 1'b1, 1'b0, bt, ld, 4'b0000};
    endfunction

    function automatic logic [11:0] e_upd(logic [1:0] w);
        return {w, 3'b000, 2'b00, 1'b0, 1'b1, 3'b000};
    endfunction

    task automatic set_a(logic mr, logic mw, logic [3:0] hv, logic [3:0] vv,
                         logic [3:0] dv, logic [1:0] lru, logic pr);
        a.mem_read  = mr;
        a.mem_write = mw;
        a.hit_vec   = hv;
        a.valid_vec = vv;
        a.dirty_vec = dv;
        a.lru_way   = lru;
        a.pmem_resp = pr;
    endtask

    task automatic set_b(logic mr, logic mw, logic [1:0] hv, logic [1:0] vv,
                         logic [1:0] dv, logic lru, logic pr);
        b.mem_read  = mr;
        b.mem_write = mw;
        b.hit_vec   = hv;
        b.valid_vec = vv;
        b.dirty_vec = dv;
        b.lru_way   = lru;
        b.pmem_resp = pr;
    endtask

    // push the expectation for the current cycle, then advance one cycle
    task automatic go(int d, logic [11:0] e, string nm);
        exp_t x;
        x.dut = d;
        x.exp = e;
        x.nm  = nm;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // monitor: compares the DUT bundle mid-cycle against the queue head
    initial begin
        exp_t e;
        logic [11:0] got;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e   = q.pop_front();
                got = (e.dut == 0) ? obs_a : obs_b;
                nvec++;
                if (got !== e.exp) begin
                    nerr++;
                    $display("FAIL %s: got %b want %b", e.nm, got, e.exp);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        set_a(0, 0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);
        set_b(0, 0, 2'b00, 2'b00, 2'b00, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        a.pmem_resp = 1'b1;
        go(0, E0, "rst_a");
        go(1, E0, "rst_b");
        rst = 1'b0;
        a.pmem_resp = 1'b0;

        // read hit on way 2
        set_a(1, 0, 4'b0100, 4'b1111, 4'b0000, 2'd0, 0);
        go(0, e_hit(2'd2, 1'b0), "hit_rd");
        set_a(0, 0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);
        go(0, E0, "idle");

        // read+write together behaves as a write
        set_a(1, 1, 4'b0001, 4'b1111, 4'b0000, 2'd0, 0);
        go(0, e_hit(2'd0, 1'b1), "hit_rw");

        // clean write miss: first invalid way (2) is the victim
        set_a(0, 1, 4'b0000, 4'b1011, 4'b0000, 2'd0, 0);
        go(0, E0, "miss_cln");
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                a.pmem_resp = 1'b0;
                go(0, e_fill(2'd2, 2'd1, 1'b0), "fill_stall");
            end
            a.pmem_resp = 1'b1;
            go(0, e_fill(2'd2, 2'(i), 1'b1), "fill");
        end
        a.pmem_resp = 1'b0;
        go(0, e_upd(2'd2), "upd");
        a.hit_vec = 4'b0100;
        go(0, e_hit(2'd2, 1'b1), "hit_wr");
        set_a(0, 0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);
        go(0, E0, "idle");

        // read miss, all valid, LRU way 1 dirty -> write-back then fill
        set_a(1, 0, 4'b0000, 4'b1111, 4'b0010, 2'd1, 0);
        go(0, E0, "miss_dty");
        a.pmem_resp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            go(0, e_evict(2'd1, 2'(i)), "evict");
        end
        for (int i = 0; i < 4; i++) begin
            go(0, e_fill(2'd1, 2'(i), 1'b1), "fill2");
        end
        a.pmem_resp = 1'b0;
        go(0, e_upd(2'd1), "upd2");
        a.hit_vec = 4'b0010;
        go(0, e_hit(2'd1, 1'b0), "hit_rd2");
        set_a(0, 0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);
        go(0, E0, "idle");

        // request dropped after beat 1 of write-back
        set_a(1, 0, 4'b0000, 4'b1111, 4'b0010, 2'd1, 0);
        go(0, E0, "miss_drop");
        a.pmem_resp = 1'b1;
        go(0, e_evict(2'd1, 2'd0), "evict_d0");
        go(0, e_evict(2'd1, 2'd1), "evict_d1");
        a.mem_read = 1'b0;
        go(0, e_evict(2'd1, 2'd2), "evict_d2");
        go(0, e_evict(2'd1, 2'd3), "evict_d3");
        a.pmem_resp = 1'b0;
        go(0, E0, "no_fill");
        go(0, E0, "no_fill2");

        // reset during fill beat 2, then restart from beat 0
        set_a(1, 0, 4'b0000, 4'b0111, 4'b0000, 2'd0, 0);
        go(0, E0, "miss_r");
        a.pmem_resp = 1'b1;
        go(0, e_fill(2'd3, 2'd0, 1'b1), "fill_r0");
        go(0, e_fill(2'd3, 2'd1, 1'b1), "fill_r1");
        rst = 1'b1;
        go(0, E0, "rst_fill");
        rst = 1'b0;
        a.mem_read = 1'b0;
        a.pmem_resp = 1'b0;
        go(0, E0, "post_rst");
        a.mem_read = 1'b1;
        go(0, E0, "miss_again");
        a.pmem_resp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            go(0, e_fill(2'd3, 2'(i), 1'b1), "restart");
        end
        a.pmem_resp = 1'b0;
        go(0, e_upd(2'd3), "upd3");
        a.hit_vec = 4'b1000;
        go(0, e_hit(2'd3, 1'b0), "hit_rd3");
        set_a(0, 0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);

        // 2-way, single-beat: clean miss on invalid way 1
        set_b(1, 0, 2'b00, 2'b01, 2'b00, 1'b0, 0);
        go(1, E0, "b_miss");
        b.pmem_resp = 1'b1;
        go(1, e_fill(2'd1, 2'd0, 1'b1), "b_fill");
        b.pmem_resp = 1'b0;
        go(1, e_upd(2'd1), "b_upd");
        b.hit_vec = 2'b10;
        go(1, e_hit(2'd1, 1'b0), "b_hit");
        set_b(0, 0, 2'b00, 2'b00, 2'b00, 1'b0, 0);
        go(1, E0, "b_idle");

        // 2-way, single-beat: dirty LRU victim 0
        set_b(0, 1, 2'b00, 2'b11, 2'b01, 1'b0, 0);
        go(1, E0, "b_miss_d");
        b.pmem_resp = 1'b1;
        go(1, e_evict(2'd0, 2'd0), "b_evict");
        go(1, e_fill(2'd0, 2'd0, 1'b1), "b_fill2");
        b.pmem_resp = 1'b0;
        go(1, e_upd(2'd0), "b_upd2");
        b.hit_vec = 2'b01;
        go(1, e_hit(2'd0, 1'b1), "b_hit_wr");
        set_b(0, 0, 2'b00, 2'b00, 2'b00, 1'b0, 0);
        go(1, E0, "b_idle2");

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            nerr++;
            $display("FAIL drain: got %0d left want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/l2_cache_ctrl_assoc.md
Name: l2_cache_ctrl_assoc

Overview:
- Control FSM for the parametrised N-way set-associative L2 cache; successor to the single-victim L2 controller.
- Sits between the L2 datapath (tag/valid/dirty arrays, data array, LRU array) and physical memory.
- Adds per-way hit/victim selection, multi-beat burst write-back/fill, explicit tag/valid/dirty/LRU update strobes, and safe handling of requests dropped mid-burst.

Parameters:
- NUM_WAYS, 4, number of ways (power of two, >= 2).
- WAY_W, $clog2(NUM_WAYS), way-index width (derived; do not override).
- BURST_BEATS, 4, pmem beats per cache line (>= 1).
- BEAT_W, (BURST_BEATS>1 ? $clog2(BURST_BEATS) : 1), beat-counter width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- mem_read  in  1  upstream read request, held until mem_resp
- mem_write  in  1  upstream write request, held until mem_resp
- hit_vec  in  NUM_WAYS  per-way tag match AND valid for the addressed set
- valid_vec  in  NUM_WAYS  per-way valid bits of the addressed set
- dirty_vec  in  NUM_WAYS  per-way dirty bits of the addressed set
- lru_way  in  WAY_W  LRU way of the addressed set, from the LRU array
- pmem_resp  in  1  one beat accepted/returned by pmem
- way_sel  out  WAY_W  way driving the data/tag muxes
- pmem_addr_sel  out  1  0 = request address, 1 = victim tag address (write-back)
- pmem_read  out  1  fill burst active
- pmem_write  out  1  write-back burst active
- beat_idx  out  BEAT_W  current beat within the line
- load_data  out  1  write the pmem beat into data[way_sel][beat_idx]
- load_tag  out  1  write tag, set valid, clear dirty for way_sel
- set_dirty  out  1  set the dirty bit of way_sel
- lru_update  out  1  mark way_sel most-recently-used
- mem_resp  out  1  upstream response

Behaviour:
- States: CHECK, EVICT, FILL, UPDATE. Reset forces CHECK, clears beat counter and victim register. All outputs default to 0 every cycle, including during reset.
- req = mem_read | mem_write.
- CHECK, hit (|hit_vec and req):
  - mem_resp=1 combinationally in the same cycle (zero-wait hit).
  - way_sel = encoded index of the hit way (hit_vec is one-hot; if not, lowest set index wins).
  - lru_update=1; set_dirty=1 iff mem_write.
  - Stay in CHECK.
- CHECK, miss (req and !|hit_vec):
  - Victim = lowest-index way with valid_vec=0; otherwise lru_way. Victim registered on this edge.
  - Go to EVICT if the victim is valid and dirty, else FILL.
  - beat counter := 0. mem_resp=0.
- CHECK, no req: idle, no strobes.
- EVICT:
  - way_sel=victim, pmem_addr_sel=1, pmem_write=1, beat_idx=counter.
  - Each pmem_resp increments the counter. On pmem_resp with counter==BURST_BEATS-1: counter:=0, go to FILL.
- FILL:
  - way_sel=victim, pmem_addr_sel=0, pmem_read=1, beat_idx=counter, load_data=pmem_resp.
  - On pmem_resp at the final beat: go to UPDATE.
- UPDATE (1 cycle): way_sel=victim, load_tag=1, go to CHECK. The next CHECK cycle then sees a hit and responds normally, which also sets LRU and dirty.
- Miss latency, clean victim: 1 + BURST_BEATS pmem beats + 1 (UPDATE) + 0 (hit cycle).
- Request dropped mid-burst (req=0 in EVICT/FILL):
  - The burst always completes; pmem strobes are never withdrawn mid-line.
  - Dropped in EVICT: finish EVICT, then return to CHECK (skip FILL). The line stays dirty; the re-write later is harmless.
  - Dropped in FILL: finish FILL and UPDATE, leaving the line valid. No mem_resp is issued for a dropped request.
- Counter wraps only via explicit clear at burst end; it never exceeds BURST_BEATS-1.
- BURST_BEATS=1: every pmem_resp is the final beat; beat_idx stays 0.
- mem_read and mem_write both high are treated as a write.
- reset asserted in any state: next cycle is CHECK with all outputs 0, regardless of pmem_resp.

Test Plan:
- NUM_WAYS=4, mem_read=1, hit_vec=4'b0100 -> same cycle mem_resp=1, way_sel=2, lru_update=1, set_dirty=0; state remains CHECK.
- mem_write=1, hit_vec=0, valid_vec=4'b1011 -> victim way 2, FILL. 4 pmem_resp pulses give beat_idx 0..3 with load_data on each. UPDATE gives load_tag=1. Then, with hit_vec=4'b0100, mem_resp=1 and set_dirty=1.
- mem_read=1, miss, valid_vec=4'b1111, lru_way=1, dirty_vec=4'b0010 -> EVICT with pmem_write=1, pmem_addr_sel=1, way_sel=1 for 4 beats. Then FILL, then UPDATE. pmem_write and pmem_read are never high together.
- Drop mem_read after beat 1 of EVICT -> beats 2,3 still issued with pmem_write=1, then CHECK with no FILL and no mem_resp.
- Assert reset mid-FILL at beat 2 -> next cycle all outputs 0, state CHECK, beat_idx=0. A subsequent miss restarts at beat 0.
- BURST_BEATS=1, NUM_WAYS=2, clean miss -> exactly one pmem_resp, then UPDATE, then hit response; total 3 cycles when pmem_resp is immediate.
